// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte FIFO drained by a bit-timing FSM.
// Consecutive queued bytes go out back-to-back with no idle gap.
module uart_tx_fifo #(
   parameter int CLK_RATE  = 25000000,
   parameter int BAUD_RATE = 115200,
   parameter int DEPTH     = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [7:0]               wr_data,
   input  logic                     wr_valid,
   output logic                     wr_ready,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic                     busy,
   output logic                     ser_tx
);

   localparam int DIVISOR = CLK_RATE / BAUD_RATE;
   localparam int AW = $clog2(DEPTH);
   localparam int CW = (DIVISOR < 2) ? 1 : $clog2(DIVISOR);
   localparam logic [CW-1:0] BAUD_MAX = CW'(DIVISOR - 1);
   localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

   if (DIVISOR < 2) begin : g_bad_divisor
      $error("uart_tx_fifo: CLK_RATE/BAUD_RATE must be at least 2");
   end

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx_fifo: DEPTH must be a power of two >= 2");
   end

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t          state;
   logic [CW-1:0]   baud_cnt;
   logic [2:0]      bit_idx;
   logic [7:0]      shift;
   logic [7:0]      mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic            push;
   logic            pop;
   logic            baud_end;
   logic            fifo_empty;

   assign fifo_empty = (fifo_level == '0);
   assign wr_ready   = (fifo_level != FULL);
   assign push       = wr_valid && wr_ready;
   assign baud_end   = (baud_cnt == BAUD_MAX);
   // Pops only at frame boundaries; a byte pushed this cycle is not yet visible.
   assign pop  = !fifo_empty && (state == IDLE || (state == STOP && baud_end));
   assign busy = (state != IDLE) || !fifo_empty;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({push, pop})
            2'b10:   fifo_level <= fifo_level + 1'b1;
            2'b01:   fifo_level <= fifo_level - 1'b1;
            default: fifo_level <= fifo_level;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         ser_tx   <= 1'b1;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shift    <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               ser_tx <= 1'b1;
               if (pop) begin
                  shift    <= mem[rd_ptr];
                  ser_tx   <= 1'b0;
                  baud_cnt <= '0;
                  state    <= START;
               end
            end
            START: begin
               if (baud_end) begin
                  baud_cnt <= '0;
                  ser_tx   <= shift[0];
                  bit_idx  <= '0;
                  state    <= DATA;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            DATA: begin
               if (baud_end) begin
                  baud_cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     ser_tx <= 1'b1;
                     state  <= STOP;
                  end else begin
                     shift   <= shift >> 1;
                     ser_tx  <= shift[1];
                     bit_idx <= bit_idx + 3'd1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            STOP: begin
               if (baud_end) begin
                  baud_cnt <= '0;
                  if (pop) begin
                     shift  <= mem[rd_ptr];
                     ser_tx <= 1'b0;
                     state  <= START;
                  end else begin
                     state  <= IDLE;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: DIVISOR 10 instance plus a DIVISOR 217
// instance for the truncated-divisor timing.
module tb_uart_tx_fifo;

   localparam int D = 10;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_valid = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       wr_ready;
   logic [4:0] fifo_level;
   logic       busy;
   logic       ser_tx;

   logic       wr_valid2 = 1'b0;
   logic [7:0] wr_data2 = 8'h00;
   logic       wr_ready2;
   logic [4:0] fifo_level2;
   logic       busy2;
   logic       ser_tx2;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int frame_err = 0;
   logic [7:0] rx_q[$];
   int st_q[$];

   uart_tx_fifo #(
      .CLK_RATE(25000000), .BAUD_RATE(2500000), .DEPTH(16)
   ) dut (
      .clk(clk), .reset(rst), .wr_data(wr_data), .wr_valid(wr_valid),
      .wr_ready(wr_ready), .fifo_level(fifo_level), .busy(busy),
      .ser_tx(ser_tx)
   );

   uart_tx_fifo #(
      .CLK_RATE(25000000), .BAUD_RATE(115200), .DEPTH(16)
   ) dut2 (
      .clk(clk), .reset(rst), .wr_data(wr_data2), .wr_valid(wr_valid2),
      .wr_ready(wr_ready2), .fifo_level(fifo_level2), .busy(busy2),
      .ser_tx(ser_tx2)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic       rst;
      logic       vld;
      logic [7:0] dat;
      logic       ser;
      logic [4:0] lvl;
      logic       bsy;
      logic       rdy;
   } vec_t;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] pk(logic s, logic [4:0] l, logic b,
                                      logic r);
      return {24'd0, s, l, b, r};
   endfunction

   function automatic logic fbit(logic [7:0] b, int idx);
      if (idx == 0) return 1'b0;
      if (idx >= 9) return 1'b1;
      return b[idx-1];
   endfunction

   // Serial monitor for dut: samples each bit at its midpoint.
   initial begin : mon
      int cnt;
      logic [7:0] sh;
      bit act;
      act = 0;
      cnt = 0;
      sh = 8'h00;
      forever begin
         @(negedge clk);
         if (rst) begin
            act = 0;
         end else if (!act) begin
            if (ser_tx == 1'b0) begin
               act = 1;
               cnt = 0;
               st_q.push_back(cyc);
            end
         end else begin
            cnt++;
            if (cnt == D / 2 && ser_tx != 1'b0) begin
               act = 0;
               frame_err++;
            end else if (cnt > D && cnt < 9 * D && (cnt % D) == D / 2) begin
               sh = {ser_tx, sh[7:1]};
            end else if (cnt == 9 * D + D / 2) begin
               if (ser_tx) rx_q.push_back(sh);
               else frame_err++;
            end
            if (cnt == 10 * D - 1) act = 0;
         end
      end
   end

   initial begin : main
      vec_t vt[6];
      int k;
      int maxl;
      int nxt;
      int run;
      int lowc;
      int hic;
      logic a;
      logic [7:0] hi[3];

      vt[0] = '{1'b1, 1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 1'b1};
      vt[1] = '{1'b1, 1'b1, 8'h77, 1'b1, 5'd0, 1'b0, 1'b1};
      vt[2] = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 1'b1};
      vt[3] = '{1'b0, 1'b1, 8'h41, 1'b1, 5'd1, 1'b1, 1'b1};
      vt[4] = '{1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b1};
      vt[5] = '{1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b1};
      hi[0] = 8'h48;
      hi[1] = 8'h69;
      hi[2] = 8'h0A;

      // Idle after reset
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      for (int i = 0; i < 50; i++) begin
         step();
         chk("t1_idle", pk(ser_tx, fifo_level, busy, wr_ready),
             pk(1'b1, 5'd0, 1'b0, 1'b1));
      end

      // Reset with discarded write, then 0x41 accepted at edge N
      for (int i = 0; i < 6; i++) begin
         rst = vt[i].rst;
         wr_valid = vt[i].vld;
         wr_data = vt[i].dat;
         step();
         chk($sformatf("vec%0d", i),
             pk(ser_tx, fifo_level, busy, wr_ready),
             pk(vt[i].ser, vt[i].lvl, vt[i].bsy, vt[i].rdy));
      end
      for (k = 3; k <= 101; k++) begin
         step();
         chk($sformatf("t2_ser_k%0d", k), 32'(ser_tx),
             32'(fbit(8'h41, (k - 1) / D)));
         chk($sformatf("t2_busy_k%0d", k), 32'(busy), 32'(k <= 100));
      end
      chk("t2_rx_count", rx_q.size(), 1);
      if (rx_q.size() == 1) chk("t2_rx_byte", 32'(rx_q[0]), 32'h41);

      // Back-to-back "Hi\n"
      rx_q.delete();
      st_q.delete();
      wr_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wr_data = hi[i];
         step();
         chk($sformatf("t3_level%0d", i), 32'(fifo_level),
             (i == 2) ? 32'd2 : 32'd1);
      end
      wr_valid = 1'b0;
      k = 2;
      maxl = 2;
      while (busy && k < 400) begin
         step();
         k++;
         if (int'(fifo_level) > maxl) maxl = int'(fifo_level);
      end
      chk("t3_busy_fall", k, 301);
      chk("t3_peak_level", maxl, 2);
      chk("t3_rx_count", rx_q.size(), 3);
      if (rx_q.size() == 3) begin
         for (int i = 0; i < 3; i++)
            chk($sformatf("t3_rx%0d", i), 32'(rx_q[i]), 32'(hi[i]));
      end
      chk("t3_start_count", st_q.size(), 3);
      if (st_q.size() == 3) begin
         chk("t3_gap01", st_q[1] - st_q[0], 10 * D);
         chk("t3_gap12", st_q[2] - st_q[1], 10 * D);
      end

      // FIFO full with incrementing pattern
      rx_q.delete();
      st_q.delete();
      nxt = 0;
      wr_valid = 1'b1;
      for (int i = 0; i < 17; i++) begin
         wr_data = 8'(nxt);
         a = wr_ready;
         step();
         if (a) nxt++;
      end
      chk("t4_accepted", nxt, 17);
      chk("t4_full", pk(1'b0, fifo_level, 1'b0, wr_ready),
          pk(1'b0, 5'd16, 1'b0, 1'b0));
      run = 0;
      k = 0;
      while (nxt < 20 && k < 1000) begin
         wr_data = 8'(nxt);
         a = wr_ready;
         if (a) begin
            run++;
         end else if (run > 0) begin
            chk("t4_ready_pulse", run, 1);
            run = 0;
         end
         step();
         k++;
         if (a) nxt++;
      end
      wr_valid = 1'b0;
      chk("t4_accepted_total", nxt, 20);
      k = 0;
      while (busy && k < 2500) begin
         step();
         k++;
      end
      chk("t4_drained", 32'(busy), 32'd0);
      chk("t4_rx_count", rx_q.size(), 20);
      if (rx_q.size() == 20) begin
         for (int i = 0; i < 20; i++)
            chk($sformatf("t4_rx%0d", i), 32'(rx_q[i]), i);
      end

      // Reset 35 cycles into the first of three queued frames
      rx_q.delete();
      st_q.delete();
      wr_valid = 1'b1;
      wr_data = 8'h11;
      step();
      wr_data = 8'h22;
      step();
      wr_data = 8'h33;
      step();
      wr_valid = 1'b0;
      for (int i = 0; i < 33; i++) step();
      chk("t5_pre_reset", pk(ser_tx, fifo_level, busy, 1'b0),
          pk(1'b0, 5'd2, 1'b1, 1'b0));
      rst = 1'b1;
      step();
      chk("t5_reset_edge", pk(ser_tx, fifo_level, busy, wr_ready),
          pk(1'b1, 5'd0, 1'b0, 1'b1));
      rst = 1'b0;
      for (int i = 0; i < 30; i++) begin
         step();
         chk("t5_quiet", pk(ser_tx, fifo_level, busy, 1'b0),
             pk(1'b1, 5'd0, 1'b0, 1'b0));
      end
      chk("t5_no_rx", rx_q.size(), 0);
      wr_valid = 1'b1;
      wr_data = 8'h55;
      step();
      wr_valid = 1'b0;
      k = 0;
      while (busy && k < 200) begin
         step();
         k++;
      end
      chk("t5_busy_fall", k, 10 * D + 1);
      chk("t5_rx_count", rx_q.size(), 1);
      if (rx_q.size() == 1) chk("t5_rx_byte", 32'(rx_q[0]), 32'h55);

      // DIVISOR 217 instance: 0x00 is low for 9 bit times
      wr_valid2 = 1'b1;
      wr_data2 = 8'h00;
      step();
      wr_valid2 = 1'b0;
      k = 0;
      while (ser_tx2 && k < 5) begin
         step();
         k++;
      end
      chk("t6_start_latency", k, 1);
      lowc = 0;
      while (!ser_tx2 && lowc < 3000) begin
         lowc++;
         step();
      end
      chk("t6_low_cycles", lowc, 1953);
      hic = 0;
      while (busy2 && hic < 400) begin
         hic++;
         step();
      end
      chk("t6_stop_cycles", hic, 217);
      chk("t6_idle", pk(ser_tx2, fifo_level2, busy2, wr_ready2),
          pk(1'b1, 5'd0, 1'b0, 1'b1));

      chk("frame_errors", frame_err, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered 8N1 UART transmitter inside `soc_top` that drives the `ser_tx` pin from CPU writes. The SoC bus adapter pushes bytes into an internal FIFO through a valid/ready port. A bit-timing FSM drains the FIFO and serialises each byte at `BAUD_RATE`. Frames from consecutive FIFO entries are sent back-to-back, so the external serial monitor sees a continuous stream with no inter-frame gap.

## Interface
- `CLK_RATE`, default 25000000: input clock frequency in Hz.
- `BAUD_RATE`, default 115200: serial bit rate. `DIVISOR = CLK_RATE/BAUD_RATE`, integer-truncated. Elaboration must fail if `DIVISOR < 2`.
- `DEPTH`, default 16: FIFO entries. Must be a power of two and at least 2.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `wr_data`  in  8  byte to transmit.
- `wr_valid`  in  1  write request.
- `wr_ready`  out  1  FIFO not full. Combinational from the level.
- `fifo_level`  out  `$clog2(DEPTH)+1`  number of queued bytes, excluding the byte in the shifter.
- `busy`  out  1  high if the FSM is not in IDLE or the FIFO is non-empty.
- `ser_tx`  out  1  serial output. Registered; idles high.

## Operation
- **Push:** a byte is pushed on a rising edge when `wr_valid && wr_ready`. FIFO order is preserved.
- **Reset:** reset has priority over everything. Any write in a reset cycle is discarded.
- **FSM states:** IDLE, START, DATA, STOP. A baud counter counts 0..`DIVISOR-1`. A 3-bit counter tracks the data bit index.
- **IDLE:**
  - `ser_tx`=1.
  - If the FIFO is non-empty: pop the head into the shift register, drive `ser_tx`<=0, clear the baud counter, go to START.
- **START:** after `DIVISOR` cycles, drive `ser_tx`<=`shift[0]`, go to DATA with bit index 0.
- **DATA:**
  - Each bit is held `DIVISOR` cycles. Bits are sent LSB first: shift right, drive the next bit.
  - After bit 7 has been held `DIVISOR` cycles, drive `ser_tx`<=1 and go to STOP.
- **STOP:** after `DIVISOR` cycles high:
  - FIFO non-empty: pop, drive `ser_tx`<=0, go to START. There is no idle cycle between frames.
  - FIFO empty: go to IDLE.
- **Level update:** push and pop in the same cycle leave `fifo_level` unchanged.
- **Full FIFO:** when full, `wr_ready`=0 and no push occurs. A pop in cycle N makes `wr_ready`=1 after edge N.
- **Counter widths:** pointers are `$clog2(DEPTH)` bits and wrap naturally. The level is one bit wider, so full (`DEPTH`) and empty (0) are distinguishable.

## Timing
- **Reset values** (output after the first edge with `reset`=1):
  - `ser_tx`=1, `fifo_level`=0, `busy`=0, `wr_ready`=1.
  - FSM in IDLE; FIFO pointers at 0.
- **Reset mid-frame:** the frame is truncated. `ser_tx` returns high on the reset edge and all queued bytes are discarded.
- **Latency:**
  - Write accepted at edge N into an empty, idle block: pop at edge N+1, where `ser_tx` falls.
  - `busy` rises after edge N.
- **Frame length:** exactly `10*DIVISOR` cycles from a start-bit falling edge to the end of the stop bit.
- **Back-to-back frames:** start bits are exactly `10*DIVISOR` cycles apart.
- **Busy fall:** `busy` falls on the edge that ends the last stop bit, when the FIFO is empty.

## Test plan
1. **Idle after reset.** Reset for 2 cycles, then idle 50 cycles. Required: `ser_tx`=1, `fifo_level`=0, `busy`=0, `wr_ready`=1 throughout.
2. **Single byte.** CLK_RATE 25000000 and BAUD_RATE 2500000 give DIVISOR 10. Write 0x41 at edge N.
   - `ser_tx` falls after N+1 and stays low 10 cycles.
   - Data bits 1,0,0,0,0,0,1,0, 10 cycles each, then stop high for 10 cycles.
   - `busy` falls at N+101; the serial monitor decodes 'A'.
3. **Back-to-back string.** Write "Hi\n" on consecutive cycles. Required: `fifo_level` peaks at 2; start bits exactly 100 cycles apart; `ser_tx` never high between a stop bit and the next start; the monitor decodes 0x48, 0x69, then `[ 10]`.
4. **FIFO full.** Hold `wr_valid`=1 with an incrementing byte pattern from 0x00 while idle.
   - 17 bytes are accepted: 1 goes to the shifter and 16 queue. Then `wr_ready`=0 and `fifo_level`=16.
   - On each STOP-to-START pop, `wr_ready` returns to 1 for one accepted write.
   - Output sequence 0x00, 0x01, … with no loss or duplication.
5. **Reset mid-frame.** Queue 3 bytes, assert reset 35 cycles into the first frame.
   - `ser_tx`=1 after the reset edge; `fifo_level`=0; `busy`=0.
   - A later write of 0x55 transmits a clean, correct frame.
6. **Non-integer divisor.** CLK_RATE 25000000 with BAUD_RATE 115200 gives DIVISOR 217. Send 0x00. Required: the start bit plus 8 data bits are low for exactly 1953 cycles, followed by a 217-cycle stop bit.
